// File: rtl/inst_fetch_queue_if.sv
// inst_fetch_queue_if
//   Bundles the instruction-memory and decode-side signals of the fetch queue.
//   master : the fetch queue (drives i_readM/i_address, inst_valid/inst/inst_pc)
//   slave  : the environment (memory + decode; drives i_ack/i_data,
//            inst_ready, redirect/redirect_pc)
//   Signals:
//     i_readM, i_address   memory read request / word address
//     i_ack, i_data        one-cycle response pulse / returned word
//     inst_valid, inst,    head entry valid / instruction word /
//     inst_pc              PC of that word
//     inst_ready           decode accepts head
//     redirect,            flush + restart fetch at redirect_pc
//     redirect_pc
interface inst_fetch_queue_if #(
  parameter int WORD_SIZE = 16
);
  logic                 i_readM;
  logic [WORD_SIZE-1:0] i_address;
  logic                 i_ack;
  logic [WORD_SIZE-1:0] i_data;
  logic                 inst_valid;
  logic [WORD_SIZE-1:0] inst;
  logic [WORD_SIZE-1:0] inst_pc;
  logic                 inst_ready;
  logic                 redirect;
  logic [WORD_SIZE-1:0] redirect_pc;

  modport master (
    output i_readM, i_address, inst_valid, inst, inst_pc,
    input  i_ack, i_data, inst_ready, redirect, redirect_pc
  );

  modport slave (
    input  i_readM, i_address, inst_valid, inst, inst_pc,
    output i_ack, i_data, inst_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue
//   Fetches instruction words from word-addressed memory (one request in
//   flight at most) and buffers them with their PCs in a DEPTH-entry FIFO
//   that feeds the decode stage over a valid/ready handshake. A redirect
//   flushes the FIFO and restarts fetch at redirect_pc; a response that is
//   still outstanding at redirect time is drained and discarded.
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous, active-high reset
//     bus    inst_fetch_queue_if.master (memory + decode signals)
//     busy   high while a request is outstanding (WAIT or DRAIN)
//   Optional build macro FETCH_HLT_STOP_EN: stop issuing requests after a
//   HLT word (opcode 15, func 29) is pushed, until redirect or reset.
module inst_fetch_queue #(
  parameter int                   WORD_SIZE = 16,
  parameter int                   DEPTH     = 4,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
  input  logic               clk,
  input  logic               reset,
  inst_fetch_queue_if.master bus,
  output logic               busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic                 i_readM_q, i_readM_d;
  logic [WORD_SIZE-1:0] i_address_q, i_address_d;
  logic [WORD_SIZE-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]        count_q, count_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic                 busy_q, busy_d;

  logic [WORD_SIZE-1:0] data_mem [DEPTH];
  logic [WORD_SIZE-1:0] pc_mem   [DEPTH];

  logic                 push;
  logic                 pop;
  logic                 stop_fetch;
  logic                 head_valid;

`ifdef FETCH_HLT_STOP_EN
  logic halted_q, halted_d;
  logic push_is_hlt;

  assign push_is_hlt = (bus.i_data[WORD_SIZE-1 -: 4] == 4'hF) &&
                       (bus.i_data[5:0] == 6'd29);
`endif

  assign head_valid = (count_q != '0);

  always_comb begin
    state_d     = state_q;
    i_readM_d   = i_readM_q;
    i_address_d = i_address_q;
    fetch_pc_d  = fetch_pc_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    push        = 1'b0;
    pop         = 1'b0;
    stop_fetch  = 1'b0;
`ifdef FETCH_HLT_STOP_EN
    halted_d    = halted_q;
`endif

    if (bus.redirect) begin
      // Flush wins over any same-cycle push/pop. An ack arriving now
      // completes the old request, so only an unanswered one needs DRAIN.
      fetch_pc_d = bus.redirect_pc;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      i_readM_d  = 1'b0;
`ifdef FETCH_HLT_STOP_EN
      halted_d   = 1'b0;
`endif
      if ((state_q != IDLE) && !bus.i_ack) begin
        state_d = DRAIN;
      end else begin
        state_d = IDLE;
      end
    end else begin
      push = (state_q == WAIT) && bus.i_ack;
      pop  = head_valid && bus.inst_ready;
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
`ifdef FETCH_HLT_STOP_EN
      if (push && push_is_hlt) begin
        halted_d = 1'b1;
      end
      stop_fetch = halted_d;
`endif
      // count_d already includes this cycle's push/pop, so a request is
      // only issued when its response slot is guaranteed free.
      unique case (state_q)
        IDLE: begin
          if ((count_d < CW'(DEPTH)) && !stop_fetch) begin
            state_d     = WAIT;
            i_readM_d   = 1'b1;
            i_address_d = fetch_pc_q;
          end
        end
        WAIT: begin
          if (bus.i_ack) begin
            fetch_pc_d = i_address_q + WORD_SIZE'(1);
            if ((count_d < CW'(DEPTH)) && !stop_fetch) begin
              i_address_d = i_address_q + WORD_SIZE'(1);
            end else begin
              state_d   = IDLE;
              i_readM_d = 1'b0;
            end
          end
        end
        DRAIN: begin
          if (bus.i_ack) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d   = IDLE;
          i_readM_d = 1'b0;
        end
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      i_readM_q   <= 1'b0;
      i_address_q <= '0;
      fetch_pc_q  <= RESET_PC;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      busy_q      <= 1'b0;
`ifdef FETCH_HLT_STOP_EN
      halted_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      i_readM_q   <= i_readM_d;
      i_address_q <= i_address_d;
      fetch_pc_q  <= fetch_pc_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      busy_q      <= busy_d;
`ifdef FETCH_HLT_STOP_EN
      halted_q    <= halted_d;
`endif
    end
  end

  // Storage needs no reset: entries are only visible through count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr_q] <= bus.i_data;
      pc_mem[wr_ptr_q]   <= i_address_q;
    end
  end

  assign bus.i_readM    = i_readM_q;
  assign bus.i_address  = i_address_q;
  assign bus.inst_valid = head_valid;
  assign bus.inst       = head_valid ? data_mem[rd_ptr_q] : '0;
  assign bus.inst_pc    = head_valid ? pc_mem[rd_ptr_q] : '0;
  assign busy           = busy_q;

endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Producer end of the instruction word consumed by the control decoder. Issues word-addressed reads to instruction memory and buffers returned 16-bit words in a small FIFO. Presents words, each with its PC, to the decode stage over a valid/ready handshake.
- Sits between instruction memory and the decode stage. Flushes and refetches on redirect (taken branch, jump, jump-register).

Parameters:
- WORD_SIZE, 16, width of instruction word, address and PC
- DEPTH, 4, FIFO entries (power of two, 2..16)
- RESET_PC, 0, first fetch address after reset

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high reset
- i_readM  output  1  memory read request; held high until i_ack
- i_address  output  WORD_SIZE  fetch address; stable while i_readM high
- i_ack  input  1  one-cycle pulse: i_data valid, request complete
- i_data  input  WORD_SIZE  returned instruction word
- inst_valid  output  1  head entry valid
- inst  output  WORD_SIZE  head instruction; 0 when inst_valid low
- inst_pc  output  WORD_SIZE  PC of head instruction; 0 when inst_valid low
- inst_ready  input  1  decode consumes head when inst_valid and inst_ready are both high
- redirect  input  1  flush and restart fetch
- redirect_pc  input  WORD_SIZE  new fetch PC, sampled when redirect is high
- busy  output  1  high in WAIT or DRAIN

Behaviour:
- Reset (async, active-high):
  - i_readM=0, i_address=0, inst_valid=0, inst=0, inst_pc=0, busy=0.
  - FIFO empty, fetch_pc=RESET_PC, state=IDLE.
  - Reset mid-request abandons the request; a late i_ack is ignored because state is IDLE.
- FSM states:
  - IDLE: no request outstanding. Move to WAIT when count < DEPTH and not halted; i_readM=1 and i_address=fetch_pc are registered outputs, asserted from the next cycle.
  - WAIT: hold i_readM and i_address stable. On i_ack:
    - push {i_data, i_address}; fetch_pc = i_address+1 (wraps at 2^WORD_SIZE-1 to 0);
    - if count after this cycle's push and pop is < DEPTH, issue the next request back-to-back (i_readM stays high, i_address=fetch_pc); else go to IDLE with i_readM=0.
  - DRAIN: entered on redirect while in WAIT without i_ack that cycle. i_readM drops; the outstanding response is awaited. On i_ack the data is discarded and the FSM goes to IDLE. Memory must not see a new request before the old ack.
- Occupancy: at most one request outstanding. The slot for the in-flight word is reserved, so a push never overflows. count + inflight <= DEPTH always.
- Latency: a word acked in cycle N appears at the head (if the FIFO was empty) with inst_valid=1 in cycle N+1. After reset release, the first i_readM is high in cycle 1.
- Simultaneous push and pop: both happen, count unchanged. Full FIFO with pop: slot frees, next request issues the following cycle.
- Redirect (highest priority):
  - FIFO cleared, inst_valid=0 the next cycle, fetch_pc=redirect_pc.
  - Any same-cycle pop or push is discarded.
  - Redirect with i_ack in the same cycle: ack consumed and data dropped; no DRAIN; the FSM goes to IDLE and fetches redirect_pc the next cycle.
  - Redirect in DRAIN: only updates fetch_pc.
- Pointers: rd/wr pointers wrap modulo DEPTH. count is a $clog2(DEPTH)+1-bit register.
- inst and inst_pc are driven from the head entry, gated to 0 when the FIFO is empty.

Optional Feature:
- Macro: FETCH_HLT_STOP_EN.
- When defined:
  - On pushing a word with opcode=15 and func (bits 5:0)=29 (HLT), set a halted flag.
  - No new requests issue while halted; words already queued still drain normally.
  - redirect or reset clears halted.
- When undefined: no halted flag; fetch continues sequentially past HLT.

Test Plan:
- Reset, memory acks every request 2 cycles after i_readM, inst_ready=1 → addresses 0,1,2,3 fetched in order; inst_pc sequence 0,1,2,3 with matching data; inst_valid first high 3 cycles after first i_readM.
- inst_ready=0, DEPTH=4 → exactly 4 requests issued, then i_readM=0, count=4. Raise inst_ready for one cycle → one pop; next request for address 4 issued the following cycle.
- Redirect to 0x0040 while in WAIT, ack arrives 3 cycles later → busy stays high through DRAIN, acked data is not pushed, next i_address=0x0040, inst_valid=0 until the word at 0x0040 returns.
- Redirect and i_ack in the same cycle, with 2 entries queued and inst_ready=1 → no pop recorded, FIFO empty next cycle, i_readM high for redirect_pc one cycle later, no DRAIN.
- fetch_pc=0xFFFF, ack → next i_address=0x0000.
- With FETCH_HLT_STOP_EN, memory returns 0xF01D at address 5 → no request to address 6; 0xF01D is delivered with inst_pc=5. A redirect to 0x0010 resumes fetching. Without the macro, address 6 is requested.
